// File: rtl/road_request_conditioner.sv
// rtl/road_request_conditioner.sv - conditions async loop sensors into latched road requests
//
// Purpose: turns raw vehicle-loop sensor levels into clean, latched highway/country
// requests for traffic_controller. Each road has a 2-flop synchroniser, a debounce
// counter and a request latch that clears only after its green has been held for at
// least MIN_SERVE cycles.
//
// Optional feature macro: PED_REQ_EN (adds ped_button, a debounced pedestrian press
// that also latches the country request).
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   raw_highway   in   async highway loop sensor (1 = vehicle present)
//   raw_country   in   async country loop sensor (1 = vehicle present)
//   ped_button    in   async pedestrian button (PED_REQ_EN builds only)
//   Greenhigh     in   highway green feedback
//   Greencountry  in   country green feedback
//   highway_road  out  registered highway request
//   country_road  out  registered country request
//   conflict      out  registered, sticky: both greens seen high on the same edge

module road_request_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_SERVE       = 8,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic green_i,
    input  logic ext_latch_i,
    output logic req_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_LATCHED, ST_SERVING} state_e;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SERVE_MIN = CNT_W'(MIN_SERVE);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            case (state_q)
                ST_IDLE: begin
                    // Latch on the sample that would bring the run to DEBOUNCE_CYCLES.
                    if (ext_latch_i || (sync2_q && cnt_q == DEB_LAST)) begin
                        state_q <= ST_LATCHED;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                    end else if (sync2_q) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                ST_LATCHED: begin
                    if (green_i) begin
                        state_q <= ST_SERVING;
                        cnt_q   <= CNT_ONE;
                    end
                end
                ST_SERVING: begin
                    if (green_i) begin
                        if (cnt_q < SERVE_MIN) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else if (cnt_q >= SERVE_MIN) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        req_q   <= 1'b0;
                    end else begin
                        // Green too short to count as service: keep the request.
                        state_q <= ST_LATCHED;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_o = req_q;
endmodule

module road_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_SERVE       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_highway,
    input  logic raw_country,
`ifdef PED_REQ_EN
    input  logic ped_button,
`endif
    input  logic Greenhigh,
    input  logic Greencountry,
    output logic highway_road,
    output logic country_road,
    output logic conflict
);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > MIN_SERVE) ? DEBOUNCE_CYCLES : MIN_SERVE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic conflict_q;
    logic ped_hit;

`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             ped_sync1_q;
    logic             ped_sync2_q;
    logic [CNT_W-1:0] ped_cnt_q;

    // A debounced press is a one-cycle hit; a held button repeats it every
    // DEBOUNCE_CYCLES samples, which only matters once country is idle again.
    assign ped_hit = ped_sync2_q && (ped_cnt_q == PED_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            ped_sync1_q <= 1'b0;
            ped_sync2_q <= 1'b0;
            ped_cnt_q   <= '0;
        end else begin
            ped_sync1_q <= ped_button;
            ped_sync2_q <= ped_sync1_q;
            if (ped_hit || !ped_sync2_q) begin
                ped_cnt_q <= '0;
            end else begin
                ped_cnt_q <= ped_cnt_q + CNT_W'(1);
            end
        end
    end
`else
    assign ped_hit = 1'b0;
`endif

    road_request_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MIN_SERVE       (MIN_SERVE),
        .CNT_W           (CNT_W)
    ) u_highway (
        .clk         (clk),
        .reset       (reset),
        .raw_i       (raw_highway),
        .green_i     (Greenhigh),
        .ext_latch_i (1'b0),
        .req_o       (highway_road)
    );

    road_request_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .MIN_SERVE       (MIN_SERVE),
        .CNT_W           (CNT_W)
    ) u_country (
        .clk         (clk),
        .reset       (reset),
        .raw_i       (raw_country),
        .green_i     (Greencountry),
        .ext_latch_i (ped_hit),
        .req_o       (country_road)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else if (Greenhigh && Greencountry) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict = conflict_q;
endmodule

// File: tb/tb_road_request_conditioner.sv
// tb/tb_road_request_conditioner.sv - self-checking bench for road_request_conditioner
module tb_road_request_conditioner;
    localparam int D = 4;
    localparam int M = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_highway = 1'b0;
    logic raw_country = 1'b0;
    logic Greenhigh = 1'b0;
    logic Greencountry = 1'b0;
`ifdef PED_REQ_EN
    logic ped_button = 1'b0;
`endif
    logic highway_road;
    logic country_road;
    logic conflict;

    int vec = 0;
    int errs = 0;

    road_request_conditioner #(.DEBOUNCE_CYCLES(D), .MIN_SERVE(M)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_highway  (raw_highway),
        .raw_country  (raw_country),
`ifdef PED_REQ_EN
        .ped_button   (ped_button),
`endif
        .Greenhigh    (Greenhigh),
        .Greencountry (Greencountry),
        .highway_road (highway_road),
        .country_road (country_road),
        .conflict     (conflict)
    );

    always #5 clk = ~clk;

    // Reference model: a request is pending or not; run = consecutive high
    // sensor samples seen two edges late; grun = length of the current green run.
    bit m_h1 [2];
    bit m_h2 [2];
    int m_run [2];
    int m_grun [2];
    bit m_pend [2];
    bit m_conf;
`ifdef PED_REQ_EN
    bit m_ph1, m_ph2;
    int m_prun;
`endif

    task automatic model_edge();
        bit raw_now, g, s, ped_hit;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_h1[c] = 0; m_h2[c] = 0; m_run[c] = 0; m_grun[c] = 0; m_pend[c] = 0;
            end
            m_conf = 0;
`ifdef PED_REQ_EN
            m_ph1 = 0; m_ph2 = 0; m_prun = 0;
`endif
            return;
        end
        ped_hit = 0;
`ifdef PED_REQ_EN
        if (m_ph2) m_prun++; else m_prun = 0;
        if (m_prun >= D) begin ped_hit = 1; m_prun = 0; end
        m_ph2 = m_ph1;
        m_ph1 = ped_button;
`endif
        for (int c = 0; c < 2; c++) begin
            raw_now = (c == 0) ? raw_highway : raw_country;
            g       = (c == 0) ? Greenhigh : Greencountry;
            s       = m_h2[c];
            if (!m_pend[c]) begin
                if (s) m_run[c]++; else m_run[c] = 0;
                if (m_run[c] >= D || (c == 1 && ped_hit)) begin
                    m_pend[c] = 1; m_run[c] = 0; m_grun[c] = 0;
                end
            end else if (g) begin
                m_grun[c]++;
            end else begin
                if (m_grun[c] >= M) begin m_pend[c] = 0; m_run[c] = 0; end
                m_grun[c] = 0;
            end
            m_h2[c] = m_h1[c];
            m_h1[c] = raw_now;
        end
        if (Greenhigh && Greencountry) m_conf = 1;
    endtask

    task automatic step(input logic rst, input logic rh, input logic rc,
                        input logic gh, input logic gc);
        reset = rst; raw_highway = rh; raw_country = rc; Greenhigh = gh; Greencountry = gc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int e = 1; e <= 2; e++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            vec++;
            if ({highway_road, country_road, conflict} !== 3'b000) begin
                errs++;
                $display("FAIL reset edge %0d: got h/c/x=%b%b%b want 000", e, highway_road, country_road, conflict);
            end
        end
        for (int e = 0; e < 4; e++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec++;
        if ({highway_road, country_road, conflict} !== 3'b000) begin
            errs++;
            $display("FAIL post_reset_idle: got h/c/x=%b%b%b want 000", highway_road, country_road, conflict);
        end
    endtask

    task automatic test_latency();
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            vec++;
            if (highway_road !== ((e >= D + 2) ? 1'b1 : 1'b0)) begin
                errs++;
                $display("FAIL latency edge %0d: got %b want %b", e, highway_road, (e >= D + 2));
            end
        end
        // Serve it for exactly MIN_SERVE cycles; it must drop on the falling-green edge.
        for (int e = 0; e < M; e++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vec++;
        if (highway_road !== 1'b1) begin
            errs++;
            $display("FAIL highway_during_green: got %b want 1", highway_road);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec++;
        if (highway_road !== 1'b0) begin
            errs++;
            $display("FAIL highway_served: got %b want 0", highway_road);
        end
    endtask

    task automatic test_glitch();
        for (int e = 0; e < 3; e++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            vec++;
            if (highway_road !== 1'b0) begin
                errs++;
                $display("FAIL glitch edge %0d: got %b want 0", e, highway_road);
            end
        end
    endtask

    task automatic test_serve();
        for (int e = 0; e < 6; e++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vec++;
        if (country_road !== 1'b1) begin
            errs++;
            $display("FAIL country_latch: got %b want 1", country_road);
        end
        for (int e = 0; e < 5; e++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int e = 0; e < 3; e++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            vec++;
            if (country_road !== 1'b1) begin
                errs++;
                $display("FAIL short_green edge %0d: got %b want 1", e, country_road);
            end
        end
        for (int e = 0; e < M; e++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec++;
        if (country_road !== 1'b0) begin
            errs++;
            $display("FAIL country_served: got %b want 0", country_road);
        end
    endtask

    task automatic test_hold_latched();
        for (int e = 0; e < 6; e++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 50; e++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec++;
        if (country_road !== 1'b1) begin
            errs++;
            $display("FAIL hold_latched: got %b want 1", country_road);
        end
        for (int e = 0; e < M; e++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec++;
        if (country_road !== 1'b0) begin
            errs++;
            $display("FAIL hold_then_served: got %b want 0", country_road);
        end
    endtask

    task automatic test_conflict();
        vec++;
        if (conflict !== 1'b0) begin
            errs++;
            $display("FAIL conflict_before: got %b want 0", conflict);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int e = 0; e < 6; e++) begin
            vec++;
            if (conflict !== 1'b1 || highway_road !== 1'b0 || country_road !== 1'b0) begin
                errs++;
                $display("FAIL conflict_sticky %0d: got x/h/c=%b%b%b want 100", e, conflict, highway_road, country_road);
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vec++;
        if (conflict !== 1'b0) begin
            errs++;
            $display("FAIL conflict_reset: got %b want 0", conflict);
        end
    endtask

    task automatic test_random();
        logic rh, rc, gh, gc;
        rh = 0; rc = 0; gh = 0; gc = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 3000; e++) begin
            if ($urandom_range(5) == 0) rh = ~rh;
            if ($urandom_range(5) == 0) rc = ~rc;
            if ($urandom_range(9) == 0) gh = ~gh;
            if ($urandom_range(9) == 0) gc = ~gc;
            step((e == 1500) ? 1'b1 : 1'b0, rh, rc, gh, gc);
            vec++;
            if (highway_road !== m_pend[0] || country_road !== m_pend[1] || conflict !== m_conf) begin
                errs++;
                $display("FAIL random cycle %0d: got h/c/x=%b%b%b want %b%b%b", e,
                         highway_road, country_road, conflict, m_pend[0], m_pend[1], m_conf);
            end
        end
    endtask

`ifdef PED_REQ_EN
    task automatic test_ped();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ped_button = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            vec++;
            if (country_road !== ((e >= D + 2) ? 1'b1 : 1'b0)) begin
                errs++;
                $display("FAIL ped edge %0d: got %b want %b", e, country_road, (e >= D + 2));
            end
        end
        ped_button = 1'b0;
        for (int e = 0; e < M; e++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vec++;
        if (country_road !== 1'b0) begin
            errs++;
            $display("FAIL ped_served: got %b want 0", country_road);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_serve();
        test_hold_latched();
        test_conflict();
        test_random();
`ifdef PED_REQ_EN
        test_ped();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
